// File: rtl/lut_table_loader_if.sv
// LUT write-port bundle shared by the table loader and the LUT RAMs.
//   wr_en    : write valid (loader -> LUT)
//   wr_sel   : 0 = direct LUT, 1 = OMS LUT
//   wr_addr  : table word address
//   wr_data  : entry value, A_W+4 bits unsigned
//   wr_ready : LUT can accept the current write (LUT -> loader)
// A_W must match the A_W of the loader instance that drives it.
interface lut_table_loader_if #(
  parameter int unsigned A_W = 8
) ();
  logic           wr_en;
  logic           wr_sel;
  logic [3:0]     wr_addr;
  logic [A_W+3:0] wr_data;
  logic           wr_ready;

  modport master (
    output wr_en,
    output wr_sel,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_sel,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/lut_table_loader.sv
// Sequential writer for the two constant-multiplier LUTs of a programmable multiplicand A.
// Fills the 8-word direct LUT (k*A, k=0..7) and then the 9-word OMS LUT ((2i+1)*A for
// i=0..7, plus 2*A at address 8), one entry per accepted write, by repeated addition.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : load request, sampled only when idle
//   a_const    : multiplicand, captured on the accepted start
//   busy       : high from the cycle after start through the final accepted write
//   done       : one-cycle pulse after the final write is accepted
//   wr         : LUT write port (valid/ready), master side
module lut_table_loader #(
  parameter int unsigned A_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [A_W-1:0]        a_const,
  output logic                  busy,
  output logic                  done,
  lut_table_loader_if.master    wr
);

  localparam int unsigned DW = A_W + 4;

  typedef enum logic [1:0] {StIdle, StDirect, StOms, StFin} state_e;

  state_e         state_q, state_d;
  logic [3:0]     addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic [A_W-1:0] a_q, a_d;

  logic           accept;
  logic [DW-1:0]  a_x1;
  logic [DW-1:0]  a_x2;

  // 15*(2^A_W-1) fits in A_W+4 bits, so the accumulator never wraps.
  assign a_x1 = DW'(a_q);
  assign a_x2 = DW'({a_q, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      a_q     <= a_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    a_d         = a_q;
    wr.wr_en    = 1'b0;
    wr.wr_sel   = 1'b0;
    wr.wr_addr  = '0;
    wr.wr_data  = '0;
    busy        = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_const;
          addr_d  = '0;
          data_d  = '0;
          state_d = StDirect;
        end
      end

      StDirect: begin
        wr.wr_en   = 1'b1;
        wr.wr_addr = addr_q;
        wr.wr_data = data_q;
        busy       = 1'b1;
        accept     = wr.wr_ready;
        if (accept) begin
          if (addr_q == 4'd7) begin
            // OMS table starts at 1*A.
            addr_d  = '0;
            data_d  = a_x1;
            state_d = StOms;
          end else begin
            addr_d = addr_q + 4'd1;
            data_d = data_q + a_x1;
          end
        end
      end

      StOms: begin
        wr.wr_en   = 1'b1;
        wr.wr_sel  = 1'b1;
        wr.wr_addr = addr_q;
        wr.wr_data = data_q;
        busy       = 1'b1;
        accept     = wr.wr_ready;
        if (accept) begin
          if (addr_q == 4'd8) begin
            state_d = StFin;
          end else if (addr_q == 4'd7) begin
            // Extra word: the even multiple 2*A.
            addr_d = 4'd8;
            data_d = a_x2;
          end else begin
            addr_d = addr_q + 4'd1;
            data_d = data_q + a_x2;
          end
        end
      end

      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader: full loads for several multiplicands, backpressure,
// start-while-busy, and reset mid-load.
module tb_lut_table_loader;

  localparam int unsigned A_W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [A_W-1:0] a_const = '0;
  logic           busy;
  logic           done;

  lut_table_loader_if #(.A_W(A_W)) wr_bus ();

  lut_table_loader #(.A_W(A_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_const (a_const),
    .busy    (busy),
    .done    (done),
    .wr      (wr_bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Record of one load as seen on the write port.
  int         acc_cnt;
  logic       acc_sel  [32];
  logic [3:0] acc_addr [32];
  logic [11:0] acc_data [32];
  int         acc_cyc  [32];
  logic       busy_log [160];
  int         done_cycle;
  int         done_count;
  int         stall_count;
  int         stable_bad;
  bit         timed_out;

  function automatic logic exp_sel(int i);
    return (i >= 8);
  endfunction

  function automatic logic [3:0] exp_addr(int i);
    if (i < 8) return 4'(i);
    if (i < 16) return 4'(i - 8);
    return 4'd8;
  endfunction

  function automatic int exp_val(int i, int a);
    if (i < 8) return i * a;
    if (i < 16) return (2 * (i - 8) + 1) * a;
    return 2 * a;
  endfunction

  // Issues start with a at the coming edge (edge 0) and follows the load until two cycles
  // past done. mode 0: wr_ready always 1; mode 1: wr_ready 1,0,0 repeating from cycle 1.
  // Optionally pulses start with inj_a in cycle inj_cycle.
  task automatic run_load(input logic [7:0] a, input int mode, input int inj_cycle,
                          input logic [7:0] inj_a);
    int c;
    bit prev_stall;
    logic psel;
    logic [3:0] paddr;
    logic [11:0] pdata;
    acc_cnt = 0; done_cycle = -1; done_count = 0; stall_count = 0; stable_bad = 0;
    timed_out = 0; prev_stall = 0; psel = 0; paddr = 0; pdata = 0;
    for (int k = 0; k < 160; k++) busy_log[k] = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a_const = a;
    wr_bus.wr_ready = 1'b0;
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      start = (c == inj_cycle);
      if (c == inj_cycle) a_const = inj_a;
      wr_bus.wr_ready = (mode == 0) ? 1'b1 : ((c % 3) == 1);
      if (prev_stall) begin
        if (wr_bus.wr_en !== 1'b1 || wr_bus.wr_sel !== psel || wr_bus.wr_addr !== paddr ||
            wr_bus.wr_data !== pdata)
          stable_bad++;
      end
      prev_stall = (wr_bus.wr_en === 1'b1) && !wr_bus.wr_ready;
      if (prev_stall) stall_count++;
      psel = wr_bus.wr_sel; paddr = wr_bus.wr_addr; pdata = wr_bus.wr_data;
      busy_log[c] = busy;
      if (wr_bus.wr_en === 1'b1 && wr_bus.wr_ready) begin
        if (acc_cnt < 32) begin
          acc_sel[acc_cnt]  = wr_bus.wr_sel;
          acc_addr[acc_cnt] = wr_bus.wr_addr;
          acc_data[acc_cnt] = wr_bus.wr_data;
          acc_cyc[acc_cnt]  = c;
        end
        acc_cnt++;
      end
      if (done === 1'b1) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (done_cycle >= 0 && c >= done_cycle + 2) break;
      if (c >= 150) begin
        timed_out = 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({wr_bus.wr_en, wr_bus.wr_sel, wr_bus.wr_addr, wr_bus.wr_data, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got en=%b sel=%b addr=%0d data=%0d busy=%b done=%b, want all 0",
               wr_bus.wr_en, wr_bus.wr_sel, wr_bus.wr_addr, wr_bus.wr_data, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_bus.wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({wr_bus.wr_en, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset: got en=%b busy=%b done=%b, want 000",
               wr_bus.wr_en, busy, done);
    end
  endtask

  task automatic test_a2();
    int exp1 [17] = '{0, 2, 4, 6, 8, 10, 12, 14, 2, 6, 10, 14, 18, 22, 26, 30, 4};
    int bad_busy;
    run_load(8'd2, 0, -1, 8'd0);
    n_vec++;
    if (timed_out || acc_cnt !== 17) begin
      n_err++;
      $display("FAIL a2_write_count: got %0d (timeout=%0d), want 17", acc_cnt, timed_out);
    end
    for (int i = 0; i < 17 && i < acc_cnt; i++) begin
      n_vec++;
      if (acc_sel[i] !== exp_sel(i) || acc_addr[i] !== exp_addr(i) ||
          acc_data[i] !== 12'(exp1[i]) || acc_cyc[i] !== i + 1) begin
        n_err++;
        $display("FAIL a2_write%0d: got sel=%b addr=%0d data=%0d cyc=%0d, want %b/%0d/%0d/%0d",
                 i, acc_sel[i], acc_addr[i], acc_data[i], acc_cyc[i], exp_sel(i), exp_addr(i),
                 exp1[i], i + 1);
      end
    end
    n_vec++;
    if (done_cycle !== 18 || done_count !== 1) begin
      n_err++;
      $display("FAIL a2_done: got cycle=%0d count=%0d, want cycle 18 count 1",
               done_cycle, done_count);
    end
    bad_busy = 0;
    for (int k = 1; k <= 17; k++) if (busy_log[k] !== 1'b1) bad_busy++;
    if (busy_log[18] !== 1'b0) bad_busy++;
    n_vec++;
    if (bad_busy != 0) begin
      n_err++;
      $display("FAIL a2_busy: got %0d bad cycles, want 0 (high 1..17, low 18)", bad_busy);
    end
  endtask

  task automatic test_a255();
    run_load(8'd255, 0, -1, 8'd0);
    n_vec++;
    if (timed_out || acc_cnt !== 17) begin
      n_err++;
      $display("FAIL a255_write_count: got %0d, want 17", acc_cnt);
    end else begin
      n_vec++;
      if (acc_data[7] !== 12'd1785) begin
        n_err++;
        $display("FAIL a255_direct7: got %0d, want 1785", acc_data[7]);
      end
      n_vec++;
      if (acc_data[15] !== 12'd3825) begin
        n_err++;
        $display("FAIL a255_oms7: got %0d, want 3825", acc_data[15]);
      end
      n_vec++;
      if (acc_data[16] !== 12'd510 || acc_addr[16] !== 4'd8) begin
        n_err++;
        $display("FAIL a255_oms8: got addr=%0d data=%0d, want addr 8 data 510",
                 acc_addr[16], acc_data[16]);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    run_load(8'd3, 1, -1, 8'd0);
    n_vec++;
    if (timed_out || acc_cnt !== 17) begin
      n_err++;
      $display("FAIL bp_write_count: got %0d (timeout=%0d), want 17", acc_cnt, timed_out);
    end
    n_vec++;
    if (stall_count == 0 || stable_bad != 0) begin
      n_err++;
      $display("FAIL bp_stable: got %0d unstable of %0d stalls, want 0 of >0",
               stable_bad, stall_count);
    end
    if (acc_cnt == 17) begin
      bad = 0;
      for (int i = 0; i < 17; i++)
        if (acc_sel[i] !== exp_sel(i) || acc_addr[i] !== exp_addr(i) ||
            acc_data[i] !== 12'(exp_val(i, 3)))
          bad++;
      n_vec++;
      if (bad != 0 || acc_data[11] !== 12'd21 || acc_data[16] !== 12'd6) begin
        n_err++;
        $display("FAIL bp_values: got %0d bad, oms3=%0d oms8=%0d, want 0 bad, 21, 6",
                 bad, acc_data[11], acc_data[16]);
      end
      n_vec++;
      if (done_count !== 1 || done_cycle !== acc_cyc[16] + 1) begin
        n_err++;
        $display("FAIL bp_done: got cycle=%0d count=%0d, want cycle %0d count 1",
                 done_cycle, done_count, acc_cyc[16] + 1);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int bad;
    run_load(8'd5, 0, 4, 8'd9);
    n_vec++;
    if (timed_out || acc_cnt !== 17 || done_count !== 1) begin
      n_err++;
      $display("FAIL swb_count: got writes=%0d dones=%0d, want 17 and 1", acc_cnt, done_count);
    end
    if (acc_cnt == 17) begin
      bad = 0;
      for (int i = 0; i < 17; i++) if (acc_data[i] !== 12'(exp_val(i, 5))) bad++;
      n_vec++;
      if (bad != 0 || acc_data[7] !== 12'd35) begin
        n_err++;
        $display("FAIL swb_values: got %0d bad, direct7=%0d, want 0 bad, 35", bad, acc_data[7]);
      end
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_bus.wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL swb_not_queued: got %0d active cycles after load, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_load();
    bit found;
    int bad;
    @(negedge clk);
    start = 1'b1;
    a_const = 8'd7;
    wr_bus.wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (wr_bus.wr_en === 1'b1 && wr_bus.wr_sel === 1'b1 && wr_bus.wr_addr === 4'd2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!found || wr_bus.wr_data !== 12'd35) begin
      n_err++;
      $display("FAIL rst_reach_oms2: got found=%0d data=%0d, want 1 and 35", found,
               wr_bus.wr_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({wr_bus.wr_en, wr_bus.wr_sel, wr_bus.wr_addr, wr_bus.wr_data, busy, done} !== '0) begin
      n_err++;
      $display("FAIL rst_async_clear: got en=%b sel=%b addr=%0d data=%0d busy=%b done=%b, want 0",
               wr_bus.wr_en, wr_bus.wr_sel, wr_bus.wr_addr, wr_bus.wr_data, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_bus.wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL rst_idle_after: got %0d active cycles, want 0", bad);
    end
    run_load(8'd1, 0, -1, 8'd0);
    bad = 0;
    for (int i = 0; i < 17 && i < acc_cnt; i++)
      if (acc_sel[i] !== exp_sel(i) || acc_addr[i] !== exp_addr(i) ||
          acc_data[i] !== 12'(exp_val(i, 1)))
        bad++;
    n_vec++;
    if (timed_out || acc_cnt !== 17 || bad != 0 || acc_data[16] !== 12'd2) begin
      n_err++;
      $display("FAIL rst_reload_a1: got writes=%0d bad=%0d oms8=%0d, want 17, 0, 2",
               acc_cnt, bad, acc_data[16]);
    end
  endtask

  task automatic test_a0();
    int bad;
    run_load(8'd0, 0, -1, 8'd0);
    bad = 0;
    for (int i = 0; i < 17 && i < acc_cnt; i++)
      if (acc_sel[i] !== exp_sel(i) || acc_addr[i] !== exp_addr(i) || acc_data[i] !== 12'd0)
        bad++;
    n_vec++;
    if (timed_out || acc_cnt !== 17 || bad != 0) begin
      n_err++;
      $display("FAIL a0_writes: got writes=%0d bad=%0d, want 17 and 0", acc_cnt, bad);
    end
    n_vec++;
    if (done_cycle !== 18 || done_count !== 1) begin
      n_err++;
      $display("FAIL a0_done: got cycle=%0d count=%0d, want 18 and 1", done_cycle, done_count);
    end
  endtask

  initial begin
    wr_bus.wr_ready = 1'b0;
    test_reset();
    test_a2();
    test_a255();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_load();
    test_a0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
